// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants, entry type and occupancy helper for the elastic pipeline register.
// PIPE_DATA_W / PIPE_CTRL_W size pipe_entry_t.
`ifndef PIPE_DATA_W
`define PIPE_DATA_W 16
`endif
`ifndef PIPE_CTRL_W
`define PIPE_CTRL_W 4
`endif

package pipe_stage_reg_pkg;

  localparam int PIPE_MAX_STAGES = 8;
  localparam int OCC_W           = 4;

  typedef struct packed {
    logic                    valid;
    logic [`PIPE_CTRL_W-1:0] ctrl;
    logic [`PIPE_DATA_W-1:0] data;
  } pipe_entry_t;

  function automatic logic [OCC_W-1:0] pipe_popcount(input logic [PIPE_MAX_STAGES-1:0] v);
    logic [OCC_W-1:0] cnt;
    cnt = {OCC_W{1'b0}};
    for (int i = 0; i < PIPE_MAX_STAGES; i++) begin
      cnt = cnt + {{(OCC_W-1){1'b0}}, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One pipeline slot: valid flag plus payload/control registers with load, hold and clear.
module pipe_stage_reg_slot
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  input  logic [CTRL_W-1:0] src_ctrl,
  output logic              valid_d,
  output logic              valid_q,
  output logic [DATA_W-1:0] data_q,
  output logic [CTRL_W-1:0] ctrl_q
);

  logic [DATA_W-1:0] data_d;
  logic [CTRL_W-1:0] ctrl_d;

  // Next-state: clear kills the flag only; payload moves only with a valid source.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (clr) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = src_valid;
    end else begin
      valid_d = valid_q;
    end
    if (load && src_valid) begin
      data_d = src_data;
      ctrl_d = src_ctrl;
    end else begin
      data_d = data_q;
      ctrl_d = ctrl_q;
    end
  end

  // Slot state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= {DATA_W{1'b0}};
      ctrl_q  <= {CTRL_W{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline register with STAGES slots, flush and bubble squeeze.
// Optional PIPE_STALL_CNT_EN adds a saturating output-stall cycle counter (stall_cnt).
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 4,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
`ifdef PIPE_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic [OCC_W-1:0]  occupancy
);

  logic [STAGES-1:0]          v_q;
  logic [STAGES-1:0]          v_d;
  logic [STAGES-1:0]          adv_s;
  logic [STAGES-1:0]          load_s;
  logic [DATA_W-1:0]          data_q [STAGES];
  logic [CTRL_W-1:0]          ctrl_q [STAGES];
  logic [PIPE_MAX_STAGES-1:0] v_pad_s;
  logic [OCC_W-1:0]           occupancy_d;
  logic [OCC_W-1:0]           occupancy_q;

  // Ready chain: a slot advances when its successor is empty or itself advancing.
  always_comb begin
    adv_s             = {STAGES{1'b0}};
    adv_s[STAGES-1]   = out_ready;
    for (int i = STAGES - 2; i >= 0; i--) begin
      adv_s[i] = !v_q[i+1] | adv_s[i+1];
    end
    load_s = ~v_q | adv_s;
  end

  assign in_ready = load_s[0] & !flush & !rst;

  for (genvar g = 0; g < STAGES; g++) begin : g_slot
    logic              src_valid_s;
    logic [DATA_W-1:0] src_data_s;
    logic [CTRL_W-1:0] src_ctrl_s;

    if (g == 0) begin : g_head
      assign src_valid_s = in_valid & in_ready;
      assign src_data_s  = in_data;
      assign src_ctrl_s  = in_ctrl;
    end else begin : g_body
      assign src_valid_s = v_q[g-1];
      assign src_data_s  = data_q[g-1];
      assign src_ctrl_s  = ctrl_q[g-1];
    end

    pipe_stage_reg_slot #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .clr       (flush),
      .load      (load_s[g]),
      .src_valid (src_valid_s),
      .src_data  (src_data_s),
      .src_ctrl  (src_ctrl_s),
      .valid_d   (v_d[g]),
      .valid_q   (v_q[g]),
      .data_q    (data_q[g]),
      .ctrl_q    (ctrl_q[g])
    );
  end

  // Occupancy tracks the next valid vector so it updates on the same edge as v.
  always_comb begin
    v_pad_s             = {PIPE_MAX_STAGES{1'b0}};
    v_pad_s[STAGES-1:0] = v_d;
    occupancy_d         = pipe_popcount(v_pad_s);
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy_q <= {OCC_W{1'b0}};
    end else begin
      occupancy_q <= occupancy_d;
    end
  end

  assign occupancy = occupancy_q;
  assign out_valid = v_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_ctrl  = ctrl_q[STAGES-1] & {CTRL_W{v_q[STAGES-1]}};

`ifdef PIPE_STALL_CNT_EN
  logic [15:0] stall_cnt_d;
  logic [15:0] stall_cnt_q;

  // Saturating count of cycles where a valid output is held off; flush leaves it alone.
  always_comb begin
    if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg (STAGES=2): directed cases plus randomized traffic
// compared every cycle against a slot-movement model. Honors PIPE_STALL_CNT_EN.
module tb_pipe_stage_reg;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [15:0] in_data;
  logic [3:0]  in_ctrl;
  logic        in_ready, out_valid;
  logic [15:0] out_data;
  logic [3:0]  out_ctrl;
  logic [3:0]  occupancy;
`ifdef PIPE_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(4), .STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
`ifdef PIPE_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .occupancy (occupancy)
  );

  // Model: each slot either holds an entry or is empty; entries step forward one slot
  // per cycle whenever the slot ahead ends the cycle empty.
  logic        m_v [S];
  logic [15:0] m_d [S];
  logic [3:0]  m_c [S];
  logic [15:0] m_last_d;
  logic [15:0] m_cnt;
  logic        p_v [S];
  logic [15:0] p_d [S];
  logic [3:0]  p_c [S];
  logic [15:0] p_last_d;
  logic        p_ready;

  function automatic void place(input int j, input logic [15:0] d, input logic [3:0] c);
    p_v[j] = 1'b1;
    p_d[j] = d;
    p_c[j] = c;
    if (j == S - 1) p_last_d = d;
  endfunction

  function automatic void model_plan();
    bit fire;
    p_last_d = m_last_d;
    for (int i = 0; i < S; i++) begin
      p_v[i] = 1'b0;
      p_d[i] = m_d[i];
      p_c[i] = m_c[i];
    end
    fire = m_v[S-1] && out_ready;
    for (int i = S - 1; i >= 0; i--) begin
      if (m_v[i] && !(i == S - 1 && fire)) begin
        if (i < S - 1 && !p_v[i+1]) place(i + 1, m_d[i], m_c[i]);
        else                        place(i, m_d[i], m_c[i]);
      end
    end
    p_ready = !p_v[0] && !flush && !rst;
    if (in_valid && p_ready) place(0, in_data, in_ctrl);
  endfunction

  function automatic void model_commit();
    if (rst) begin
      for (int i = 0; i < S; i++) begin
        m_v[i] = 1'b0;
        m_d[i] = 16'h0;
        m_c[i] = 4'h0;
      end
      m_last_d = 16'h0;
      m_cnt    = 16'h0;
    end else begin
      if (m_v[S-1] && !out_ready && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      model_plan();
      for (int i = 0; i < S; i++) begin
        m_v[i] = flush ? 1'b0 : p_v[i];
        m_d[i] = p_d[i];
        m_c[i] = p_c[i];
      end
      m_last_d = p_last_d;
    end
  endfunction

  function automatic int model_occ();
    int n = 0;
    for (int i = 0; i < S; i++) n += int'(m_v[i]);
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, mid-cycle with inputs stable.
  always @(negedge clk) begin
    if (chk_en) begin
      model_plan();
      chk("m_in_ready",  {31'd0, in_ready},  {31'd0, p_ready});
      chk("m_out_valid", {31'd0, out_valid}, {31'd0, m_v[S-1]});
      chk("m_out_data",  {16'd0, out_data},  {16'd0, m_last_d});
      chk("m_out_ctrl",  {28'd0, out_ctrl},  {28'd0, (m_v[S-1] ? m_c[S-1] : 4'h0)});
      chk("m_occupancy", {28'd0, occupancy}, 32'(model_occ()));
`ifdef PIPE_STALL_CNT_EN
      chk("m_stall_cnt", {16'd0, stall_cnt}, {16'd0, m_cnt});
`endif
    end
  end

  task automatic drive(input logic r, input logic f, input logic iv, input logic [15:0] d,
                       input logic [3:0] c, input logic ordy);
    rst = r; flush = f; in_valid = iv; in_data = d; in_ctrl = c; out_ready = ordy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  logic [15:0] rcv[$];
  int          k;
  bit          acc;
  int unsigned rdy_pct;

  initial begin
    for (int i = 0; i < S; i++) begin
      m_v[i] = 1'b0; m_d[i] = 16'h0; m_c[i] = 4'h0;
    end
    m_last_d = 16'h0;
    m_cnt    = 16'h0;
    drive(1'b1, 1'b0, 1'b1, 16'h0, 4'h0, 1'b1);
    tick();
    chk_en = 1'b1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  {16'd0, out_data},  32'd0);
    chk("rst_out_ctrl",  {28'd0, out_ctrl},  32'd0);
    chk("rst_occupancy", {28'd0, occupancy}, 32'd0);

    // Two-cycle latency, then bubbles mask ctrl but keep stale data.
    drive(1'b0, 1'b0, 1'b1, 16'h1234, 4'b0101, 1'b1);
    chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 1'b1);
    chk("t1_lat1_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("t1_lat2_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_lat2_data",  {16'd0, out_data},  32'h1234);
    chk("t1_lat2_ctrl",  {28'd0, out_ctrl},  32'h5);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t5_bubble_valid", {31'd0, out_valid}, 32'd0);
      chk("t5_bubble_ctrl",  {28'd0, out_ctrl},  32'd0);
      chk("t5_stale_data",   {16'd0, out_data},  32'h1234);
    end

    // Stream 1..8 with a three-cycle downstream stall.
    k = 1;
    for (int c = 1; c <= 40 && rcv.size() < 8; c++) begin
      drive(1'b0, 1'b0, k <= 8, 16'(k), 4'(k), !(c >= 3 && c <= 5));
      if (c == 3) begin
        chk("t2_full_in_ready",  {31'd0, in_ready},  32'd0);
        chk("t2_full_occupancy", {28'd0, occupancy}, 32'd2);
      end
      if (out_valid && out_ready) rcv.push_back(out_data);
      acc = in_valid && in_ready;
      tick();
      if (acc) k++;
    end
    chk("t2_count", 32'(rcv.size()), 32'd8);
    for (int i = 0; i < 8 && i < rcv.size(); i++) chk("t2_order", {16'd0, rcv[i]}, 32'(i + 1));

    // Flush of a full pipe drops the concurrent input.
    drive(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b1, 16'hAAAA, 4'h1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 16'hBBBB, 4'h2, 1'b0);
    tick();
    chk("t3_full_occ",  {28'd0, occupancy}, 32'd2);
    chk("t3_full_data", {16'd0, out_data},  32'hAAAA);
    drive(1'b0, 1'b1, 1'b1, 16'hCCCC, 4'h3, 1'b0);
    chk("t3_flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 1'b1);
    chk("t3_post_valid", {31'd0, out_valid}, 32'd0);
    chk("t3_post_occ",   {28'd0, occupancy}, 32'd0);
    chk("t3_post_ctrl",  {28'd0, out_ctrl},  32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_no_cccc_valid", {31'd0, out_valid}, 32'd0);
      chk("t3_no_cccc_data",  {16'd0, out_data},  32'hAAAA);
    end

    // Mid-stream reset.
    drive(1'b0, 1'b0, 1'b1, 16'h5555, 4'hF, 1'b0);
    tick();
    tick();
    drive(1'b1, 1'b0, 1'b1, 16'h6666, 4'h3, 1'b1);
    chk("t4_rst_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 16'h7777, 4'h9, 1'b1);
    chk("t4_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t4_out_data",  {16'd0, out_data},  32'd0);
    chk("t4_occ",       {28'd0, occupancy}, 32'd0);
    chk("t4_release_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("t4_accept_occ", {28'd0, occupancy}, 32'd1);

`ifdef PIPE_STALL_CNT_EN
    drive(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 16'h1111, 4'h1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) tick();
    chk("t6_stall5", {16'd0, stall_cnt}, 32'd5);
    drive(1'b0, 1'b1, 1'b0, 16'h0, 4'h0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 1'b1);
    tick();
    chk("t6_flush_keeps", {16'd0, stall_cnt}, 32'd5);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 1'b1);
    tick();
    chk("t6_rst_clears", {16'd0, stall_cnt}, 32'd0);
`endif

    // Randomized traffic with shifting back-pressure.
    rdy_pct = 50;
    for (int n = 0; n < 1500; n++) begin
      if (n % 100 == 0) rdy_pct = $urandom_range(10, 100);
      drive(($urandom % 100) == 0, ($urandom % 16) == 0, ($urandom % 4) != 0,
            16'($urandom), 4'($urandom), $urandom_range(1, 100) <= rdy_pct);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
